// File: rtl/position_encoder.sv
// Keypad position encoder: qualifies a stable one-hot key request and presents
// its 4-bit cell index to the game controller over a valid/ready handshake.
module position_encoder #(
   parameter int N_POS         = 16,
   parameter int POS_W         = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [N_POS-1:0] key_in,
   input  logic             enable,
   output logic [POS_W-1:0] pos_out,
   output logic             pos_valid,
   input  logic             pos_ready,
   output logic             multi_err,
   output logic             busy
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [N_POS-1:0] ONE = N_POS'(1);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD,
      WAIT_RELEASE
   } state_t;

   state_t           state, state_d;
   logic [N_POS-1:0] snapshot, snapshot_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [POS_W-1:0] pos_d;
   logic             valid_d, err_d;
   logic [POS_W-1:0] index;
   logic             one_hot;

   // Clearing the lowest set bit leaves zero only when exactly one bit was set.
   assign one_hot = (snapshot != '0) && ((snapshot & (snapshot - ONE)) == '0);

   always_comb begin
      index = '0;
      for (int i = 0; i < N_POS; i++) begin
         if (snapshot[i]) index = POS_W'(i);
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d    = state;
      snapshot_d = snapshot;
      cnt_d      = cnt;
      pos_d      = pos_out;
      valid_d    = pos_valid;
      err_d      = 1'b0;

      unique case (state)
         IDLE: begin
            if (enable && key_in != '0) begin
               snapshot_d = key_in;
               cnt_d      = '0;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (!enable || key_in == '0) begin
               state_d = IDLE;
            end else if (key_in != snapshot) begin
               snapshot_d = key_in;
               cnt_d      = '0;
            end else if (cnt != CNT_LAST) begin
               cnt_d = cnt + 1'b1;
            end else if (one_hot) begin
               pos_d   = index;
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               err_d   = 1'b1;
               state_d = WAIT_RELEASE;
            end
         end
         HOLD: begin
            if (pos_ready) begin
               valid_d = 1'b0;
               state_d = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (key_in == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         snapshot  <= '0;
         cnt       <= '0;
         pos_out   <= '0;
         pos_valid <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         state     <= state_d;
         snapshot  <= snapshot_d;
         cnt       <= cnt_d;
         pos_out   <= pos_d;
         pos_valid <= valid_d;
         multi_err <= err_d;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_position_encoder.sv
// Directed bench for position_encoder: expected cell indices are queued when a
// key is driven and popped when the controller side accepts a move.
module tb_position_encoder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] key_in;
   logic        enable;
   logic [3:0]  pos_out;
   logic        pos_valid;
   logic        pos_ready;
   logic        multi_err;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int exp_q[$];

   position_encoder #(.N_POS(16), .POS_W(4), .STABLE_CYCLES(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .key_in    (key_in),
      .enable    (enable),
      .pos_out   (pos_out),
      .pos_valid (pos_valid),
      .pos_ready (pos_ready),
      .multi_err (multi_err),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: notes whether this edge accepts a move, then samples 1ns after the edge.
   task automatic cycle();
      logic       acc;
      logic [3:0] seen;
      int         want;
      acc  = pos_valid && pos_ready;
      seen = pos_out;
      @(posedge clock);
      #1;
      if (acc) begin
         check("accept_queue", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("accepted_pos", 32'(seen), 32'(want));
         end
      end
   endtask

   // Key already driven: expects valid exactly after the 4th edge following the first sample.
   task automatic expect_latency(input int p);
      logic early;
      cycle();
      check("settle_busy", 32'(busy), 32'd1);
      early = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         early = early | pos_valid;
      end
      check("early_valid", 32'(early), 32'd0);
      cycle();
      check("valid_rise", 32'(pos_valid), 32'd1);
      check("pos_out", 32'(pos_out), 32'(p));
      check("no_err_with_valid", 32'(multi_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic flag;
      reset_n   = 1'b0;
      key_in    = '0;
      enable    = 1'b0;
      pos_ready = 1'b0;
      #12;
      check("rst_pos_out", 32'(pos_out), 32'd0);
      check("rst_valid", 32'(pos_valid), 32'd0);
      check("rst_err", 32'(multi_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Basic move
      enable    = 1'b1;
      pos_ready = 1'b1;
      key_in    = 16'h0020;
      exp_q.push_back(5);
      expect_latency(5);
      cycle();
      check("basic_valid_drop", 32'(pos_valid), 32'd0);
      check("basic_wait_busy", 32'(busy), 32'd1);
      key_in = '0;
      cycle();
      check("basic_idle", 32'(busy), 32'd0);

      // Backpressure
      pos_ready = 1'b0;
      key_in    = 16'h8000;
      exp_q.push_back(15);
      expect_latency(15);
      key_in = 16'h0001;
      flag   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (!(pos_valid && pos_out == 4'd15)) flag = 1'b0;
      end
      check("bp_stable", 32'(flag), 32'd1);
      pos_ready = 1'b1;
      cycle();
      check("bp_valid_drop", 32'(pos_valid), 32'd0);
      cycle();
      check("bp_still_waiting", 32'(busy), 32'd1);
      key_in = '0;
      cycle();
      check("bp_idle", 32'(busy), 32'd0);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Bounce
      flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         key_in = (i % 2 == 1) ? 16'h0004 : 16'h0000;
         cycle();
         flag = flag | pos_valid;
      end
      check("bounce_no_valid", 32'(flag), 32'd0);
      key_in = 16'h0004;
      exp_q.push_back(2);
      expect_latency(2);
      cycle();
      key_in = '0;
      cycle();

      // Multi-key
      key_in = 16'h0011;
      cycle();
      for (int i = 0; i < 3; i++) cycle();
      check("multi_err_low_early", 32'(multi_err), 32'd0);
      cycle();
      check("multi_err_pulse", 32'(multi_err), 32'd1);
      check("multi_no_valid", 32'(pos_valid), 32'd0);
      cycle();
      check("multi_err_one_cycle", 32'(multi_err), 32'd0);
      flag = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (!busy || pos_valid || multi_err) flag = 1'b0;
      end
      check("multi_wait_release", 32'(flag), 32'd1);
      key_in = '0;
      cycle();
      check("multi_idle", 32'(busy), 32'd0);
      key_in = 16'h0200;
      exp_q.push_back(9);
      expect_latency(9);
      cycle();
      key_in = '0;
      cycle();

      // Held key yields one move only
      key_in = 16'h0008;
      exp_q.push_back(3);
      expect_latency(3);
      cycle();
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         flag = flag | pos_valid;
      end
      check("held_no_second", 32'(flag), 32'd0);
      key_in = '0;
      cycle();

      // Enable dropped during SETTLE
      key_in = 16'h0040;
      cycle();
      cycle();
      enable = 1'b0;
      cycle();
      check("en_drop_idle", 32'(busy), 32'd0);
      flag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         flag = flag | pos_valid | busy;
      end
      check("en_low_ignored", 32'(flag), 32'd0);
      key_in = '0;
      enable = 1'b1;
      cycle();

      // Reset during HOLD
      pos_ready = 1'b0;
      key_in    = 16'h0002;
      exp_q.push_back(1);
      expect_latency(1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(pos_valid), 32'd0);
      check("async_rst_pos", 32'(pos_out), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(posedge clock);
      #1;
      reset_n   = 1'b1;
      pos_ready = 1'b1;
      exp_q.push_back(1);
      expect_latency(1);
      cycle();
      key_in = '0;
      cycle();

      // Sweep every cell
      for (int i = 0; i < 16; i++) begin
         logic [15:0] k;
         logic [15:0] dec;
         k      = 16'h0001 << i;
         key_in = k;
         exp_q.push_back(i);
         expect_latency(i);
         dec = 16'h0001 << pos_out;
         check("sweep_decode", 32'(dec), 32'(k));
         cycle();
         key_in = '0;
         cycle();
      end
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/position_encoder.md
Name: position_encoder

Overview:
- Reverse of the board's position decoder: converts a player's 16-bit one-hot keypad request into a 4-bit board position with a valid/ready handshake to the game controller.
- Qualifies each request for stability and rejects multi-key presses.
- Holds the encoded position until the controller accepts it, then requires all keys released before the next move (one move per press).
- Sits between the keypad synchronisers and the game FSM; the controller's position decoder consumes pos_out.

Parameters:
- N_POS, 16, number of board cells (one key per cell).
- POS_W, 4, width of the encoded position; equals clog2(N_POS).
- STABLE_CYCLES, 4, consecutive identical samples required before a request is accepted (minimum 1).

Ports:
- clock  input  1  single system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_in  input  N_POS  synchronised key levels; bit i = cell i requested.
- enable  input  1  accept new requests when high (player's turn).
- pos_out  output  POS_W  encoded cell index; valid only while pos_valid=1.
- pos_valid  output  1  encoded position available.
- pos_ready  input  1  controller accepts pos_out this cycle.
- multi_err  output  1  one-cycle pulse: a stable request had more than one key set.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; pos_out=0, pos_valid=0, multi_err=0, busy=0.
  - Internal snapshot and counter cleared.
  - Reset mid-handshake drops the pending move; no valid after release until a new full qualification.
- FSM states: IDLE, SETTLE, HOLD, WAIT_RELEASE.
- IDLE:
  - If enable=1 and key_in!=0: snapshot<=key_in, cnt<=0, go SETTLE.
  - Otherwise stay in IDLE.
- SETTLE, evaluated each edge in priority order:
  - enable=0 -> IDLE.
  - key_in==0 -> IDLE (glitch discarded).
  - key_in!=snapshot -> snapshot<=key_in, cnt<=0, stay in SETTLE.
  - key_in==snapshot and cnt<STABLE_CYCLES-1 -> cnt+1.
  - key_in==snapshot and cnt==STABLE_CYCLES-1:
    - snapshot exactly one-hot: pos_out<=index of set bit, pos_valid<=1, go HOLD.
    - otherwise: multi_err<=1 for one cycle, go WAIT_RELEASE.
- Latency: if key_in is first seen at edge k and stays constant, pos_valid rises after edge k+STABLE_CYCLES (default: 4 cycles after the first sample).
- HOLD:
  - pos_valid=1; pos_out stable; key_in and enable are ignored.
  - On an edge with pos_ready=1: pos_valid<=0, go WAIT_RELEASE.
  - pos_ready may be high before valid; acceptance is the first edge with valid&&ready, giving a minimum one-cycle HOLD.
- WAIT_RELEASE: go IDLE on the first edge where key_in==0. A held key never produces a second move.
- One-hot check: popcount(snapshot)==1. Encoding is the exact inverse of the position decoder, so decode(pos_out)==snapshot for every accepted move.
- multi_err: high only for the single cycle after the rejecting edge; never coincides with pos_valid.
- busy = (state!=IDLE).
- Width rules:
  - cnt is wide enough for STABLE_CYCLES-1.
  - pos_out is zero-extended from the priority index.
  - N_POS < 2^POS_W is legal; upper indices are unused.

Test Plan:
- Basic move: enable=1, key_in=16'h0020 held for 6 cycles; pos_ready=1 -> pos_valid high after 4 cycles with pos_out=5; accepted the next edge; IDLE once key_in=0.
- Backpressure: key_in=16'h8000, pos_ready=0 for 10 cycles then 1 -> pos_out=15 and pos_valid stay constant for 10 cycles; a key_in change to 16'h0001 during HOLD has no effect; exactly one acceptance.
- Bounce: key_in toggles 16'h0004/16'h0000 every cycle for 5 cycles, then 16'h0004 steady -> no valid during the bounce; pos_out=2 exactly 4 cycles after the steady value starts.
- Multi-key: key_in=16'h0011 steady -> multi_err pulses for exactly 1 cycle, pos_valid never asserts; no activity until key_in=0, then 16'h0200 yields pos_out=9.
- Hold and enable: after acceptance of pos_out=3, key_in stays 16'h0008 for 20 cycles -> no second valid. Separately, enable drops in SETTLE -> IDLE with no valid.
- Reset and sweep: reset_n pulsed low during HOLD -> outputs 0 asynchronously. Then sweep all 16 one-hot keys -> pos_out=i each time and decode(pos_out)==key_in.
